hol_round_judge: RTL
====================

Name: hol_round_judge

Overview:
Upstream stage of the high-or-low game. It generates the displayed number (0..99), latches the player's HIGH/LOW keypad answer, and judges it against the previously shown number. It drives the 7-bit binary number and an active-low point strobe into the game display/scoring module. That module converts the number to BCD/font and inverts the strobe into `point`.

Parameters:
LFSR_SEED, 8'hA5, non-zero reset seed of the 8-bit LFSR
PREV_INIT, 7'd50, reference "previous" value for the first round of a game
KEY_HIGH, 4'hA, keypad code meaning "current number is higher than previous"
KEY_LOW, 4'hB, keypad code meaning "current number is lower than previous"
POINT_HOLD, 50, clk_100 cycles point_n is held low after a correct answer (0.5 s)
GAME_ID, 3'b010, game_en value that enables this game

Ports:
clk_100  input  1  100 Hz system clock
rst_n  input  1  asynchronous active-low reset
game_en  input  3  game select; block active only when equal to GAME_ID
key  input  4  keypad code, valid while pressed=1
pressed  input  1  level, high while a key is held
rand_out  output  7  currently displayed number, 0..99, binary
point_out  output  1  active-low point strobe (point_n), low for POINT_HOLD cycles per correct answer

Behaviour:
- Reset value and synchronicity: one clock (clk_100); rst_n asynchronous, active-low.
- Reset values: rand_out=0, point_out=1, prev=PREV_INIT, lfsr=LFSR_SEED, press_d=0, hold counter=0, state=IDLE.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle in all states, never zero.
  - Map to 0..99: c=lfsr[6:0]; if c>=100 then c=c-28 (100..127 -> 72..99).
  - If c equals the value it replaces, use c+1, with 99 wrapping to 0.
- Edge detect: press_d registers pressed. A press event is pressed & ~press_d, with key sampled in the same cycle.
- State machine:
  - IDLE: point_out=1, rand_out held. When game_en==GAME_ID, go to SHOW next cycle, load rand_out with mapped value (must differ from prev), and set prev=PREV_INIT.
  - SHOW: wait for a press event.
    - key==KEY_HIGH or key==KEY_LOW: capture the answer and go to JUDGE.
    - Any other key: ignore and stay in SHOW.
  - JUDGE (exactly 1 cycle): correct = (ans==HIGH && rand_out>prev) || (ans==LOW && rand_out<prev).
    - Update prev<=rand_out and rand_out<=new mapped value (≠ old rand_out).
    - If correct: load hold counter with POINT_HOLD-1, drive point_out=0 from the next cycle, go to FEEDBACK.
    - If wrong: go to SHOW.
  - FEEDBACK: point_out=0; counter decrements each cycle. When the counter is 0, set point_out=1 and go to SHOW. Press events during FEEDBACK are dropped.
- Latency: press edge at cycle N -> JUDGE at N+1 -> point_out low during N+2 .. N+1+POINT_HOLD.
- Equality with prev cannot occur, because the new value is always forced different.
- game_en leaving GAME_ID in any state: next cycle go to IDLE, point_out=1, counter cleared, rand_out held.
- pressed held across many cycles counts as a single event. A press arriving in the same cycle as the game becomes enabled is ignored.
- Reset mid-FEEDBACK: point_out returns to 1 immediately (asynchronous).

Decomposition:
- Shared include (global.v): GAME_ID_HOL, KEY_HIGH/KEY_LOW codes, state encodings (IDLE=2'd0, SHOW=2'd1, JUDGE=2'd2, FEEDBACK=2'd3).
- One sub-module: lfsr_rand_00_99, holding the LFSR plus the mod-100 mapping and the not-equal adjust. Inputs clk_100, rst_n, exclude[6:0]; output val[6:0].

Test Plan:
1. Assert rst_n=0, then release with game_en=0 -> rand_out=0 and point_out=1 for 100 cycles; the LFSR output is never 0.
2. Set game_en=3'b010 -> within 2 cycles rand_out is in 0..99 and ≠50. If rand_out>50, press KEY_HIGH for 1 cycle -> point_out low for exactly 50 cycles, starting 2 cycles after the edge.
3. Repeat scenario 2 with the wrong key (KEY_LOW when rand_out>50) -> point_out stays 1; rand_out changes to a new value ≠ old one cycle after JUDGE; prev equals the old value.
4. Hold pressed=1 with KEY_HIGH for 30 cycles -> exactly one judgement. Press key=4'h3 -> no state change, rand_out unchanged.
5. Correct answer, then drop game_en to 0 at cycle 10 of FEEDBACK -> point_out=1 next cycle. Re-enable -> new round with prev=50.
6. Run 10,000 random rounds and check against a reference model: every rand_out ≤99, consecutive values always differ, and each point pulse length is 50.

Source files
------------

// File: rtl/hol_round_judge_pkg.sv
// Shared definitions for the high-or-low round judge: default codes, FSM state
// encoding and the LFSR / 0..99 mapping helpers used by the number generator.
package hol_round_judge_pkg;

    // Default block configuration
    localparam logic [2:0]  GAME_ID_HOL    = 3'b010;
    localparam logic [3:0]  KEY_HIGH_CODE  = 4'hA;
    localparam logic [3:0]  KEY_LOW_CODE   = 4'hB;
    localparam logic [6:0]  PREV_INIT_DEF  = 7'd50;
    localparam logic [7:0]  LFSR_SEED_DEF  = 8'hA5;
    localparam int unsigned POINT_HOLD_DEF = 50;

    // Round state; encodings match the display/scoring side's view of the game
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StShow     = 2'd1,
        StJudge    = 2'd2,
        StFeedback = 2'd3
    } state_e;

    // One step of the 8-bit Fibonacci LFSR, taps 8,6,5,4 (1-based)
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Fold a 7-bit raw value into 0..99 and step past the excluded value
    function automatic logic [6:0] map_0_99(input logic [6:0] raw, input logic [6:0] excl);
        logic [6:0] c;
        c = (raw >= 7'd100) ? raw - 7'd28 : raw;
        if (c == excl) begin
            c = (c == 7'd99) ? 7'd0 : c + 7'd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hol_round_judge_lfsr.sv
// Random number source for the high-or-low game: a free-running 8-bit LFSR
// whose low seven bits are folded into 0..99, never equal to 'exclude'.
module hol_round_judge_lfsr
    import hol_round_judge_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic [6:0] exclude,
    output logic [6:0] val
);

    logic [7:0] r_lfsr;

    // LFSR advances every cycle; an all-zero state (only reachable by upset) reloads the seed
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_lfsr == 8'h00) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign val = map_0_99(r_lfsr[6:0], exclude);

endmodule

// File: rtl/hol_round_judge.sv
// High-or-low round judge: shows a number, latches the HIGH/LOW answer on a
// key press edge, judges it against the previous number and emits an
// active-low point strobe for POINT_HOLD cycles on a correct answer.
module hol_round_judge
    import hol_round_judge_pkg::*;
#(
    parameter logic [7:0]  LFSR_SEED  = LFSR_SEED_DEF,
    parameter logic [6:0]  PREV_INIT  = PREV_INIT_DEF,
    parameter logic [3:0]  KEY_HIGH   = KEY_HIGH_CODE,
    parameter logic [3:0]  KEY_LOW    = KEY_LOW_CODE,
    parameter int unsigned POINT_HOLD = POINT_HOLD_DEF,
    parameter logic [2:0]  GAME_ID    = GAME_ID_HOL
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic [2:0] game_en,
    input  logic [3:0] key,
    input  logic       pressed,
    output logic [6:0] rand_out,
    output logic       point_out
);

    localparam int unsigned CNT_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(POINT_HOLD - 1);

    state_e           r_state;
    logic [6:0]       r_rand;
    logic [6:0]       r_prev;
    logic             r_point_n;
    logic             r_press_d;
    logic             r_ans_high;
    logic [CNT_W-1:0] r_cnt;

    logic       w_game_on;
    logic       w_press_evt;
    logic       w_key_answer;
    logic       w_correct;
    logic [6:0] w_exclude;
    logic [6:0] w_new_val;

    assign w_game_on    = (game_en == GAME_ID);
    assign w_press_evt  = pressed & ~r_press_d;
    assign w_key_answer = (key == KEY_HIGH) || (key == KEY_LOW);
    assign w_correct    = r_ans_high ? (r_rand > r_prev) : (r_rand < r_prev);

    // A fresh game is judged against PREV_INIT, so the first number must avoid it;
    // afterwards each new number must avoid the one it replaces.
    assign w_exclude = (r_state == StIdle) ? PREV_INIT : r_rand;

    hol_round_judge_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .exclude (w_exclude),
        .val     (w_new_val)
    );

    // Delayed copy of 'pressed' so a held key yields a single press event
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_press_d <= 1'b0;
        end else begin
            r_press_d <= pressed;
        end
    end

    // Round FSM with registered number, reference value and point strobe
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_rand     <= 7'd0;
            r_prev     <= PREV_INIT;
            r_point_n  <= 1'b1;
            r_ans_high <= 1'b0;
            r_cnt      <= '0;
        end else if (!w_game_on) begin
            // Leaving the game abandons any pulse but keeps the shown number
            r_state   <= StIdle;
            r_point_n <= 1'b1;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_rand    <= w_new_val;
                    r_prev    <= PREV_INIT;
                    r_point_n <= 1'b1;
                    r_state   <= StShow;
                end
                StShow: begin
                    if (w_press_evt && w_key_answer) begin
                        r_ans_high <= (key == KEY_HIGH);
                        r_state    <= StJudge;
                    end
                end
                StJudge: begin
                    r_prev <= r_rand;
                    r_rand <= w_new_val;
                    if (w_correct) begin
                        r_cnt     <= HOLD_INIT;
                        r_point_n <= 1'b0;
                        r_state   <= StFeedback;
                    end else begin
                        r_state <= StShow;
                    end
                end
                StFeedback: begin
                    if (r_cnt == '0) begin
                        r_point_n <= 1'b1;
                        r_state   <= StShow;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign rand_out  = r_rand;
    assign point_out = r_point_n;

endmodule
